pinmux_cfg: RTL and testbench

PINMUX_CFG -- requirements
Module: pinmux_cfg

---
 rtl/pinmux_cfg.sv | 134 +++++++++++++
 tb/tb_pinmux_cfg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pinmux_cfg.sv
// Pad multiplexer with a small register file: per-pad 2-bit function selects, sticky LOCK, pad input status.
// Optional macro PINMUX_IN_SYNC_EN adds a two-flop mclk synchronizer on the pad inputs.
module pinmux_cfg #(
    parameter int                NPIN      = 38,
    parameter logic [2*NPIN-1:0] RESET_SEL = '0
) (
    input  logic              mclk,
    input  logic              h_reset_n,
    input  logic              reg_cs,
    input  logic              reg_wr,
    input  logic [2:0]        reg_addr,
    input  logic [3:0]        reg_be,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              reg_ack,
    input  logic [4*NPIN-1:0] func_out,
    input  logic [4*NPIN-1:0] func_oe_n,
    output logic [4*NPIN-1:0] func_in,
    input  logic [NPIN-1:0]   io_in,
    output logic [NPIN-1:0]   io_out,
    output logic [NPIN-1:0]   io_oeb
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2*NPIN-1:0] r_sel;
    logic [2*NPIN-1:0] w_sel_wr;
    logic              r_lock;
    logic [31:0]       r_rdata;
    logic [31:0]       w_rdata;
    logic [127:0]      w_sel_pad;
    logic [63:0]       w_in_pad;
    logic [NPIN-1:0]   w_io_in_s;

`ifdef PINMUX_IN_SYNC_EN
    logic [NPIN-1:0] r_sync1;
    logic [NPIN-1:0] r_sync2;

    always_ff @(posedge mclk) begin
        if (!h_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= io_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_io_in_s = r_sync2;
`else
    assign w_io_in_s = io_in;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (reg_cs) w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Zero-extended views so pads beyond NPIN read back as 0.
    always_comb begin
        w_sel_pad = '0;
        w_sel_pad[2*NPIN-1:0] = r_sel;
        w_in_pad = '0;
        w_in_pad[NPIN-1:0] = w_io_in_s;
    end

    always_comb begin
        w_rdata = '0;
        case (reg_addr)
            3'd0, 3'd1, 3'd2, 3'd3: w_rdata = w_sel_pad[{reg_addr[1:0], 5'b0} +: 32];
            3'd4:    w_rdata = {31'b0, r_lock};
            3'd5:    w_rdata = w_in_pad[31:0];
            3'd6:    w_rdata = w_in_pad[63:32];
            default: w_rdata = '0;
        endcase
    end

    always_comb begin
        w_sel_wr = r_sel;
        for (int i = 0; i < 2*NPIN; i++) begin
            if (reg_addr[1:0] == 2'(i / 32) && reg_be[(i % 32) / 8])
                w_sel_wr[i] = reg_wdata[i % 32];
        end
    end

    always_ff @(posedge mclk) begin
        if (!h_reset_n) begin
            r_state <= S_IDLE;
            r_sel   <= RESET_SEL;
            r_lock  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && reg_cs) begin
                r_rdata <= reg_wr ? 32'd0 : w_rdata;
                if (reg_wr) begin
                    if (reg_addr < 3'd4 && !r_lock)
                        r_sel <= w_sel_wr;
                    if (reg_addr == 3'd4 && reg_wdata[0])
                        r_lock <= 1'b1;
                end
            end else begin
                r_rdata <= '0;
            end
        end
    end

    assign reg_ack   = (r_state == S_ACK);
    assign reg_rdata = r_rdata;

    // Pad path is purely combinational from the select registers.
    always_comb begin
        io_out  = '0;
        io_oeb  = '1;
        func_in = '0;
        for (int p = 0; p < NPIN; p++) begin
            if (r_sel[2*p +: 2] != 2'd0) begin
                io_out[p] = func_out[4*p + int'(r_sel[2*p +: 2])];
                io_oeb[p] = func_oe_n[4*p + int'(r_sel[2*p +: 2])];
            end
            func_in[4*p + int'(r_sel[2*p +: 2])] = w_io_in_s[p];
        end
    end

endmodule

// File: tb/tb_pinmux_cfg.sv
// Directed testbench for pinmux_cfg: registers, pad routing, lock, input path, handshake and reset abort.
module tb_pinmux_cfg;
    localparam int NPIN = 38;

    logic              mclk;
    logic              h_reset_n;
    logic              reg_cs;
    logic              reg_wr;
    logic [2:0]        reg_addr;
    logic [3:0]        reg_be;
    logic [31:0]       reg_wdata;
    logic [31:0]       reg_rdata;
    logic              reg_ack;
    logic [4*NPIN-1:0] func_out;
    logic [4*NPIN-1:0] func_oe_n;
    logic [4*NPIN-1:0] func_in;
    logic [NPIN-1:0]   io_in;
    logic [NPIN-1:0]   io_out;
    logic [NPIN-1:0]   io_oeb;

    int nchk = 0;
    int nerr = 0;

    pinmux_cfg #(.NPIN(NPIN), .RESET_SEL('0)) dut (
        .mclk(mclk), .h_reset_n(h_reset_n), .reg_cs(reg_cs), .reg_wr(reg_wr),
        .reg_addr(reg_addr), .reg_be(reg_be), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack), .func_out(func_out),
        .func_oe_n(func_oe_n), .func_in(func_in), .io_in(io_in),
        .io_out(io_out), .io_oeb(io_oeb)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one access and reports ack latency, ack width, read data and pad state at ack.
    task automatic access(input logic wr, input logic [2:0] a, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat,
                          output int ack_len, output logic [NPIN-1:0] po,
                          output logic [NPIN-1:0] pe);
        lat = -1; ack_len = 0; rd = '0; po = '0; pe = '0;
        @(negedge mclk);
        reg_cs = 1'b1; reg_wr = wr; reg_addr = a; reg_be = be; reg_wdata = wd;
        for (int c = 1; c <= 8; c++) begin
            @(posedge mclk); #1;
            if (reg_ack) begin
                lat = c; rd = reg_rdata; po = io_out; pe = io_oeb;
                break;
            end
        end
        reg_cs = 1'b0; reg_wr = 1'b0;
        if (lat > 0) begin
            ack_len = 1;
            @(posedge mclk); #1;
            if (reg_ack) ack_len = 2;
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd; int lat, al; logic [NPIN-1:0] po, pe;
        h_reset_n = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        nchk++; if (reg_ack !== 1'b0) begin nerr++; $display("FAIL reset_ack got=%b exp=0", reg_ack); end
        nchk++; if (reg_rdata !== 32'd0) begin nerr++; $display("FAIL reset_rdata got=%h exp=0", reg_rdata); end
        @(negedge mclk) h_reset_n = 1'b1;
        @(posedge mclk); #1;
        nchk++; if (io_oeb !== {NPIN{1'b1}}) begin nerr++; $display("FAIL reset_oeb got=%h exp=all ones", io_oeb); end
        nchk++; if (io_out !== '0) begin nerr++; $display("FAIL reset_out got=%h exp=0", io_out); end
        nchk++; if (func_in !== '0) begin nerr++; $display("FAIL reset_func_in got=%h exp=0", func_in); end
        for (int a = 0; a <= 4; a++) begin
            access(1'b0, 3'(a), 4'h0, 32'd0, rd, lat, al, po, pe);
            nchk++; if (lat !== 1) begin nerr++; $display("FAIL reset_read_lat addr=%0d got=%0d exp=1", a, lat); end
            nchk++; if (rd !== 32'd0) begin nerr++; $display("FAIL reset_read addr=%0d got=%h exp=0", a, rd); end
        end
    endtask

    task automatic test_select_write;
        logic [31:0] rd; int lat, al; logic [NPIN-1:0] po, pe;
        func_out[5] = 1'b1; func_oe_n[5] = 1'b0; io_in[1] = 1'b1;
        access(1'b1, 3'd0, 4'hF, 32'h0000_0004, rd, lat, al, po, pe);
        nchk++; if (lat !== 1) begin nerr++; $display("FAIL sel_lat got=%0d exp=1", lat); end
        nchk++; if (al !== 1) begin nerr++; $display("FAIL sel_ack_len got=%0d exp=1", al); end
        nchk++; if (po[1] !== 1'b1) begin nerr++; $display("FAIL sel_out_at_ack got=%b exp=1", po[1]); end
        nchk++; if (pe[1] !== 1'b0) begin nerr++; $display("FAIL sel_oeb_at_ack got=%b exp=0", pe[1]); end
        @(negedge mclk);
        func_out[5] = 1'b0; func_oe_n[5] = 1'b1;
        #1;
        nchk++; if (io_out[1] !== 1'b0) begin nerr++; $display("FAIL sel_out_follow got=%b exp=0", io_out[1]); end
        nchk++; if (io_oeb[1] !== 1'b1) begin nerr++; $display("FAIL sel_oeb_follow got=%b exp=1", io_oeb[1]); end
        nchk++; if (func_in[7:4] !== 4'b0010) begin nerr++; $display("FAIL sel_func_in got=%b exp=0010", func_in[7:4]); end
        access(1'b0, 3'd0, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'h0000_0004) begin nerr++; $display("FAIL sel_readback got=%h exp=00000004", rd); end
        io_in[1] = 1'b0;
    endtask

    task automatic test_byte_enables;
        logic [31:0] rd; int lat, al; logic [NPIN-1:0] po, pe;
        access(1'b1, 3'd1, 4'h1, 32'hFFFF_FFFF, rd, lat, al, po, pe);
        access(1'b0, 3'd1, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'h0000_00FF) begin nerr++; $display("FAIL be_lane0 got=%h exp=000000ff", rd); end
        @(negedge mclk);
        func_out[67] = 1'b1; func_oe_n[67] = 1'b0; func_out[82] = 1'b1; func_oe_n[82] = 1'b0;
        #1;
        nchk++; if (io_out[16] !== 1'b1) begin nerr++; $display("FAIL be_pad16_out got=%b exp=1", io_out[16]); end
        nchk++; if (io_oeb[16] !== 1'b0) begin nerr++; $display("FAIL be_pad16_oeb got=%b exp=0", io_oeb[16]); end
        nchk++; if (io_oeb[20] !== 1'b1) begin nerr++; $display("FAIL be_pad20_safe got=%b exp=1", io_oeb[20]); end
        access(1'b1, 3'd1, 4'h2, 32'h0000_AA00, rd, lat, al, po, pe);
        access(1'b0, 3'd1, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'h0000_AAFF) begin nerr++; $display("FAIL be_lane1 got=%h exp=0000aaff", rd); end
        nchk++; if (io_out[20] !== 1'b1) begin nerr++; $display("FAIL be_pad20_f2 got=%b exp=1", io_out[20]); end
        access(1'b1, 3'd2, 4'hF, 32'hFFFF_FFFF, rd, lat, al, po, pe);
        access(1'b0, 3'd2, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'h0000_0FFF) begin nerr++; $display("FAIL be_partial_word got=%h exp=00000fff", rd); end
        access(1'b1, 3'd3, 4'hF, 32'hFFFF_FFFF, rd, lat, al, po, pe);
        access(1'b0, 3'd3, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'd0) begin nerr++; $display("FAIL be_absent_word got=%h exp=0", rd); end
    endtask

    task automatic test_status_read;
        logic [31:0] rd; int lat, al; logic [NPIN-1:0] po, pe;
        io_in = 38'h2A_1234_5678;
        repeat (3) @(posedge mclk);
        access(1'b0, 3'd5, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'h1234_5678) begin nerr++; $display("FAIL stat_lo got=%h exp=12345678", rd); end
        access(1'b0, 3'd6, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'h0000_002A) begin nerr++; $display("FAIL stat_hi got=%h exp=0000002a", rd); end
        access(1'b1, 3'd5, 4'hF, 32'hFFFF_FFFF, rd, lat, al, po, pe);
        nchk++; if (lat !== 1) begin nerr++; $display("FAIL stat_wr_ack got=%0d exp=1", lat); end
        access(1'b0, 3'd5, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'h1234_5678) begin nerr++; $display("FAIL stat_ro got=%h exp=12345678", rd); end
        access(1'b1, 3'd7, 4'hF, 32'hFFFF_FFFF, rd, lat, al, po, pe);
        access(1'b0, 3'd7, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'd0) begin nerr++; $display("FAIL addr7 got=%h exp=0", rd); end
    endtask

    task automatic test_input_sync;
        logic [31:0] rd; int lat, al; logic [NPIN-1:0] po, pe;
        io_in = '0;
        repeat (4) @(posedge mclk);
        @(negedge mclk) io_in[2] = 1'b1;
`ifdef PINMUX_IN_SYNC_EN
        @(posedge mclk); #1;
        nchk++; if (func_in[8] !== 1'b0) begin nerr++; $display("FAIL sync_cycle1 got=%b exp=0", func_in[8]); end
        @(posedge mclk); #1;
        nchk++; if (func_in[8] !== 1'b1) begin nerr++; $display("FAIL sync_cycle2 got=%b exp=1", func_in[8]); end
`else
        #1;
        nchk++; if (func_in[8] !== 1'b1) begin nerr++; $display("FAIL in_comb got=%b exp=1", func_in[8]); end
`endif
        nchk++; if (func_in[11:9] !== 3'b000) begin nerr++; $display("FAIL in_other_funcs got=%b exp=000", func_in[11:9]); end
        access(1'b0, 3'd5, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'h0000_0004) begin nerr++; $display("FAIL in_status got=%h exp=00000004", rd); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] acks;
        logic [31:0] rd1, rd2;
        @(negedge mclk);
        reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = 3'd0;
        for (int c = 0; c < 4; c++) begin
            @(posedge mclk); #1;
            acks[c] = reg_ack;
            if (c == 0) rd1 = reg_rdata;
            if (c == 1) rd2 = reg_rdata;
        end
        reg_cs = 1'b0;
        nchk++; if (acks !== 4'b0101) begin nerr++; $display("FAIL b2b_ack_pattern got=%b exp=0101", acks); end
        nchk++; if (rd1 !== 32'h0000_0004) begin nerr++; $display("FAIL b2b_rdata got=%h exp=00000004", rd1); end
        nchk++; if (rd2 !== 32'd0) begin nerr++; $display("FAIL b2b_rdata_idle got=%h exp=0", rd2); end
    endtask

    task automatic test_lock;
        logic [31:0] rd; int lat, al; logic [NPIN-1:0] po, pe;
        access(1'b1, 3'd4, 4'hF, 32'h0000_0001, rd, lat, al, po, pe);
        access(1'b1, 3'd0, 4'hF, 32'hFFFF_FFFF, rd, lat, al, po, pe);
        nchk++; if (lat !== 1) begin nerr++; $display("FAIL lock_wr_ack got=%0d exp=1", lat); end
        access(1'b0, 3'd0, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'h0000_0004) begin nerr++; $display("FAIL lock_sel_kept got=%h exp=00000004", rd); end
        access(1'b0, 3'd4, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'h0000_0001) begin nerr++; $display("FAIL lock_set got=%h exp=00000001", rd); end
        access(1'b1, 3'd4, 4'hF, 32'h0000_0000, rd, lat, al, po, pe);
        access(1'b0, 3'd4, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'h0000_0001) begin nerr++; $display("FAIL lock_sticky got=%h exp=00000001", rd); end
    endtask

    task automatic test_abort;
        logic [31:0] rd; int lat, al; logic [NPIN-1:0] po, pe;
        @(negedge mclk);
        h_reset_n = 1'b0;
        reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = 3'd0; reg_be = 4'hF; reg_wdata = 32'hFFFF_FFFF;
        @(posedge mclk); #1;
        nchk++; if (reg_ack !== 1'b0) begin nerr++; $display("FAIL abort_ack0 got=%b exp=0", reg_ack); end
        @(negedge mclk);
        h_reset_n = 1'b1; reg_cs = 1'b0; reg_wr = 1'b0;
        @(posedge mclk); #1;
        nchk++; if (reg_ack !== 1'b0) begin nerr++; $display("FAIL abort_ack1 got=%b exp=0", reg_ack); end
        nchk++; if (io_oeb !== {NPIN{1'b1}}) begin nerr++; $display("FAIL abort_oeb got=%h exp=all ones", io_oeb); end
        access(1'b0, 3'd0, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'd0) begin nerr++; $display("FAIL abort_sel got=%h exp=0", rd); end
        access(1'b0, 3'd4, 4'h0, 32'd0, rd, lat, al, po, pe);
        nchk++; if (rd !== 32'd0) begin nerr++; $display("FAIL abort_lock_clear got=%h exp=0", rd); end
    endtask

    initial begin
        h_reset_n = 1'b0; reg_cs = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_be = '0;
        reg_wdata = '0; func_out = '0; func_oe_n = '1; io_in = '0;
        test_reset;
        test_select_write;
        test_byte_enables;
        test_status_read;
        test_input_sync;
        test_back_to_back;
        test_lock;
        test_abort;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
